// File: rtl/i2c_bit_phy.sv
// Bit-level I2C line driver: turns per-bit SCL mode / SDA commands into open-drain
// pull-down enables, generates the sequencer's bit clock and handles clock stretching.
module i2c_bit_phy #(
  parameter int DIV_Q = 125,
  parameter int CW    = $clog2(DIV_Q)
) (
  input  logic clk,
  input  logic reset,
  input  logic ctrl_d,
  input  logic ctrl_h,
  input  logic ctrl_l,
  input  logic sda_w,
  input  logic sda_in,
  input  logic scl_in,
  output logic clk2,
  output logic sda_rx,
  output logic sda_oe,
  output logic scl_oe,
  output logic stretch
);

  typedef enum logic [1:0] {
    PH_0 = 2'd0,
    PH_1 = 2'd1,
    PH_2 = 2'd2,
    PH_3 = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    MODE_D = 2'b00,
    MODE_L = 2'b01,
    MODE_H = 2'b10,
    MODE_S = 2'b11
  } mode_t;

  phase_t        r_phase;
  phase_t        w_phase_nxt;
  mode_t         r_mode;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_scl_s1;
  logic          r_scl_s2;
  logic          r_sda_s1;
  logic          w_cnt_last;
  logic          w_capture;
  logic          w_stretch;
  logic          w_wrap;
  logic          w_scl_nxt;
  logic          w_clk2_nxt;

  assign w_cnt_last = (r_cnt == CW'(DIV_Q - 1));
  assign w_capture  = (r_phase == PH_0) && (r_cnt == CW'(DIV_Q / 2 - 1));
  // A slave holding SCL low at the end of the high-going phase freezes the bit timing.
  assign w_stretch  = (r_phase == PH_1) && w_cnt_last && !scl_oe && !r_scl_s2;
  assign w_wrap     = w_cnt_last && !w_stretch;
  assign stretch    = w_stretch;

  always_comb begin
    w_cnt_nxt   = r_cnt + CW'(1);
    w_phase_nxt = r_phase;
    if (w_stretch) begin
      w_cnt_nxt = r_cnt;
    end else if (w_cnt_last) begin
      w_cnt_nxt = '0;
      case (r_phase)
        PH_0:    w_phase_nxt = PH_1;
        PH_1:    w_phase_nxt = PH_2;
        PH_2:    w_phase_nxt = PH_3;
        default: w_phase_nxt = PH_0;
      endcase
    end
  end

  // SCL and clk2 only move on phase boundaries; phase 0 keeps the previous bit's SCL.
  always_comb begin
    w_scl_nxt  = scl_oe;
    w_clk2_nxt = clk2;
    if (w_wrap) begin
      case (w_phase_nxt)
        PH_1:    w_scl_nxt = (r_mode == MODE_L);
        PH_2:    w_scl_nxt = (r_mode == MODE_L) || (r_mode == MODE_S);
        PH_3:    w_scl_nxt = (r_mode != MODE_H);
        default: w_scl_nxt = scl_oe;
      endcase
      if (w_phase_nxt == PH_0) w_clk2_nxt = 1'b1;
      if (w_phase_nxt == PH_2) w_clk2_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_phase <= PH_0;
      clk2    <= 1'b0;
      scl_oe  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      clk2    <= w_clk2_nxt;
      scl_oe  <= w_scl_nxt;
    end
  end

  // Commands are sampled once per bit, mid phase 0, while SCL is guaranteed low or steady.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mode <= MODE_H;
      sda_oe <= 1'b0;
    end else if (w_capture) begin
      r_mode <= mode_t'({ctrl_h, ctrl_l});
      sda_oe <= ctrl_d & ~sda_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_sda_s1 <= 1'b1;
      sda_rx   <= 1'b1;
    end else begin
      r_scl_s1 <= scl_in;
      r_scl_s2 <= r_scl_s1;
      r_sda_s1 <= sda_in;
      sda_rx   <= r_sda_s1;
    end
  end

endmodule

// File: tb/tb_i2c_bit_phy.sv
// Directed bench for i2c_bit_phy at DIV_Q=4: per-bit line waveforms, start/stop,
// ACK sampling, clock stretching and asynchronous reset.
module tb_i2c_bit_phy;
  localparam int DIV_Q = 4;

  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic ctrl_d = 1'b1;
  logic ctrl_h = 1'b1;
  logic ctrl_l = 1'b0;
  logic sda_w  = 1'b1;
  logic sda_in = 1'b1;
  logic scl_in = 1'b1;
  logic clk2, sda_rx, sda_oe, scl_oe, stretch;

  int checks   = 0;
  int failures = 0;

  logic s_scl[64];
  logic s_sda[64];
  logic s_clk2[64];
  logic s_rx[64];
  logic s_str[64];
  logic [15:0] v_scl, v_sda, v_clk2, v_rx;

  i2c_bit_phy #(.DIV_Q(DIV_Q)) dut (
    .clk     (clk),
    .reset   (reset),
    .ctrl_d  (ctrl_d),
    .ctrl_h  (ctrl_h),
    .ctrl_l  (ctrl_l),
    .sda_w   (sda_w),
    .sda_in  (sda_in),
    .scl_in  (scl_in),
    .clk2    (clk2),
    .sda_rx  (sda_rx),
    .sda_oe  (sda_oe),
    .scl_oe  (scl_oe),
    .stretch (stretch)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_bit(input logic h, input logic l, input logic d, input logic w);
    ctrl_h = h;
    ctrl_l = l;
    ctrl_d = d;
    sda_w  = w;
  endtask

  // Leaves the bench at the negedge inside cycle 0 of the next bit (clk2 just rose).
  task automatic sync_bit();
    logic prev;
    logic found;
    prev  = clk2;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (clk2 === 1'b1 && prev === 1'b0) found = 1'b1;
      prev = clk2;
    end
    check_eq("bit_sync", {31'd0, found}, 32'd1);
  endtask

  task automatic record_bit(input int n, input int lo_from, input int lo_to);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      s_scl[i]  = scl_oe;
      s_sda[i]  = sda_oe;
      s_clk2[i] = clk2;
      s_rx[i]   = sda_rx;
      s_str[i]  = stretch;
      if (i < 16) begin
        v_scl[i]  = scl_oe;
        v_sda[i]  = sda_oe;
        v_clk2[i] = clk2;
        v_rx[i]   = sda_rx;
      end
      if (i == lo_from) scl_in = 1'b0;
      if (i == lo_to)   scl_in = 1'b1;
    end
  endtask

  task automatic run_bit(input logic h, input logic l, input logic d, input logic w,
                         input logic [15:0] exp_scl, input logic [15:0] exp_sda,
                         input string name);
    sync_bit();
    set_bit(h, l, d, w);
    record_bit(16, -1, -1);
    check_eq({name, "_scl"}, {16'd0, v_scl}, {16'd0, exp_scl});
    check_eq({name, "_sda"}, {16'd0, v_sda}, {16'd0, exp_sda});
  endtask

  initial begin
    int str_cnt;
    int rise_at;

    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_clk2",    {31'd0, clk2},    32'd0);
    check_eq("rst_scl_oe",  {31'd0, scl_oe},  32'd0);
    check_eq("rst_sda_oe",  {31'd0, sda_oe},  32'd0);
    check_eq("rst_stretch", {31'd0, stretch}, 32'd0);
    check_eq("rst_sda_rx",  {31'd0, sda_rx},  32'd1);
    set_bit(1'b0, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;

    // Bit vectors: bit i is the value during cycle i of the bit (cycle 0 = clk2 rise).
    run_bit(1'b0, 1'b0, 1'b1, 1'b1, 16'hF00F, 16'h0000, "data1");
    check_eq("data1_clk2", {16'd0, v_clk2}, 32'h0000_00FF);
    run_bit(1'b1, 1'b0, 1'b1, 1'b1, 16'h000F, 16'h0000, "idle");
    run_bit(1'b1, 1'b1, 1'b1, 1'b0, 16'hFF00, 16'hFFFC, "start");
    run_bit(1'b1, 1'b0, 1'b1, 1'b0, 16'h000F, 16'hFFFF, "stop_lo");
    run_bit(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0003, "stop_hi");
    run_bit(1'b0, 1'b0, 1'b1, 1'b0, 16'hF000, 16'hFFFC, "data0");

    // ACK slot: SDA released, slave pulls low.
    sync_bit();
    set_bit(1'b0, 1'b0, 1'b0, 1'b0);
    sda_in = 1'b0;
    record_bit(16, -1, -1);
    check_eq("ack_scl",   {16'd0, v_scl}, 32'h0000_F00F);
    check_eq("ack_sda",   {16'd0, v_sda}, 32'h0000_0003);
    check_eq("ack_rx",    {16'd0, v_rx},  32'h0000_0003);
    check_eq("ack_rx_c8", {31'd0, s_rx[8]}, 32'd0);

    // Stretch: SCL held low by the slave for cycles 4..23.
    sync_bit();
    set_bit(1'b0, 1'b0, 1'b1, 1'b1);
    sda_in = 1'b1;
    record_bit(40, 4, 24);
    str_cnt = 0;
    rise_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (s_str[i] === 1'b1) str_cnt++;
      if (i > 0 && rise_at < 0 && s_clk2[i] === 1'b1 && s_clk2[i-1] === 1'b0) rise_at = i;
    end
    check_eq("str_c6",     {31'd0, s_str[6]},  32'd0);
    check_eq("str_c7",     {31'd0, s_str[7]},  32'd1);
    check_eq("str_c25",    {31'd0, s_str[25]}, 32'd1);
    check_eq("str_c26",    {31'd0, s_str[26]}, 32'd0);
    check_eq("str_count",  str_cnt,            32'd19);
    check_eq("str_scl_c7", {31'd0, s_scl[7]},  32'd0);
    check_eq("str_clk2_c26", {31'd0, s_clk2[26]}, 32'd1);
    check_eq("str_clk2_c27", {31'd0, s_clk2[27]}, 32'd0);
    check_eq("str_scl_c30",  {31'd0, s_scl[30]},  32'd0);
    check_eq("str_scl_c31",  {31'd0, s_scl[31]},  32'd1);
    check_eq("str_period", rise_at, 32'd35);

    // Reset in phase 2 of a data bit driving SDA low.
    sync_bit();
    set_bit(1'b0, 1'b0, 1'b1, 1'b0);
    sda_in = 1'b0;
    record_bit(10, -1, -1);
    check_eq("pre_rst_sda", {31'd0, s_sda[9]},  32'd1);
    check_eq("pre_rst_rx",  {31'd0, s_rx[9]},   32'd0);
    check_eq("pre_rst_clk2", {31'd0, s_clk2[9]}, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_scl",  {31'd0, scl_oe}, 32'd0);
    check_eq("mid_rst_sda",  {31'd0, sda_oe}, 32'd0);
    check_eq("mid_rst_clk2", {31'd0, clk2},   32'd0);
    check_eq("mid_rst_rx",   {31'd0, sda_rx}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rise_at = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (rise_at < 0 && clk2 === 1'b1) rise_at = k;
    end
    check_eq("post_rst_rise", rise_at, 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
